// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared types and constants for the instruction fetch unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0000_0000, instr: NOP_INSTR, valid: 1'b0};

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register, priority flush > stall > load
// Revision  : 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  stall_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t r_q;
  ifid_t r_d;

  always_comb begin
    r_d = r_q;
    if (flush_i) begin
      r_d = IFID_BUBBLE;
    end else if (!stall_i) begin
      r_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= IFID_BUBBLE;
    end else begin
      r_q <= r_d;
    end
  end

  assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : IF stage with request FSM, holding buffer and redirect drop.
//              Optional perf counters enabled by macro FETCH_PERF_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        stall_IF,
  input  logic        flush_ID,
  input  logic        EX_br_sel,
  input  logic [31:0] EX_br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_instr,
  output logic        ID_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  fetch_state_e state_q, state_d;
  logic         live_q;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        buf_q, buf_d;
  ifid_t        ifid_d;
  ifid_t        ifid_q;

  logic [31:0]  w_tgt;
  logic         w_ack;
  logic [31:0]  w_addr_inc;

  // live_q keeps the request low until one full edge after reset release,
  // so an ack belonging to an abandoned transaction cannot be consumed.
  assign imem_req   = live_q && (state_q != ST_HOLD);
  assign imem_addr  = req_addr_q;
  assign w_ack      = imem_req && imem_ack;
  assign w_tgt      = align_word(EX_br_target);
  assign w_addr_inc = req_addr_q + 32'd4;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_REQ;
      live_q     <= 1'b0;
      req_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      buf_q      <= IFID_BUBBLE;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      req_addr_q <= req_addr_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    ifid_d     = IFID_BUBBLE;
    if (live_q) begin
      unique case (state_q)
        ST_REQ: begin
          if (EX_br_sel) begin
            pc_d = w_tgt;
            if (w_ack) begin
              req_addr_d = w_tgt;
            end else begin
              state_d = ST_DROP;
            end
          end else if (w_ack) begin
            pc_d = w_addr_inc;
            if (stall_IF) begin
              buf_d   = '{pc: req_addr_q, instr: imem_rdata, valid: 1'b1};
              state_d = ST_HOLD;
            end else begin
              ifid_d     = '{pc: req_addr_q, instr: imem_rdata, valid: 1'b1};
              req_addr_d = w_addr_inc;
            end
          end
        end
        ST_HOLD: begin
          if (EX_br_sel) begin
            buf_d      = IFID_BUBBLE;
            pc_d       = w_tgt;
            req_addr_d = w_tgt;
            state_d    = ST_REQ;
          end else if (!stall_IF) begin
            ifid_d     = buf_q;
            buf_d      = IFID_BUBBLE;
            req_addr_d = pc_q;
            state_d    = ST_REQ;
          end
        end
        ST_DROP: begin
          // The stale word is thrown away; only the redirect target survives.
          if (EX_br_sel) begin
            pc_d = w_tgt;
          end
          if (w_ack) begin
            req_addr_d = EX_br_sel ? w_tgt : pc_q;
            state_d    = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .stall_i (stall_IF),
    .flush_i (flush_ID),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign ID_pc    = ifid_q.pc;
  assign ID_instr = ifid_q.instr;
  assign ID_valid = ifid_q.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubbles_q;
  logic        w_ld_valid;
  logic        w_ld_bubble;

  assign w_ld_valid  = !flush_ID && !stall_IF && ifid_d.valid;
  assign w_ld_bubble = flush_ID || (!stall_IF && !ifid_d.valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      if (w_ld_valid) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (w_ld_bubble) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

`default_nettype wire
